// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response channel plus the decode-facing
// instruction port and the redirect/stall controls from later stages.
interface instr_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        jump_branch_enable;
    logic [31:0] jump_target;
    logic        stall;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output instruction,
        output instr_pc,
        output instr_valid,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  jump_branch_enable,
        input  jump_target,
        input  stall
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  instruction,
        input  instr_pc,
        input  instr_valid,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output jump_branch_enable,
        output jump_target,
        output stall
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word read, registered decode output and a
// one-entry holding buffer that absorbs a response arriving while decode is stalled.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StHold
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        kill_q, kill_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic        jump;
    logic [31:0] target;
    logic        req_fire;
    logic        rsp_take;
    logic        out_free;
    logic        rsp_to_out;

    assign jump       = bus.jump_branch_enable;
    assign target     = bus.jump_target & ~32'h3;
    assign req_fire   = (state_q == StReq) && bus.imem_req_ready;
    // A redirect in the same cycle as the response throws that response away.
    assign rsp_take   = (state_q == StWait) && bus.imem_rsp_valid && !kill_q && !jump;
    assign out_free   = !valid_q || !bus.stall;
    assign rsp_to_out = rsp_take && out_free && !buf_valid_q;

    // Decode-facing output register and holding buffer.
    always_comb begin
        instr_d     = instr_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        buf_pc_d    = buf_pc_q;

        if (jump) begin
            instr_d     = NOP_INSTR;
            valid_d     = 1'b0;
            buf_valid_d = 1'b0;
        end else begin
            if (out_free) begin
                if (buf_valid_q) begin
                    instr_d     = buf_data_q;
                    pc_d        = buf_pc_q;
                    valid_d     = 1'b1;
                    buf_valid_d = 1'b0;
                end else if (rsp_take) begin
                    instr_d = bus.imem_rsp_data;
                    pc_d    = req_pc_q;
                    valid_d = 1'b1;
                end else begin
                    instr_d = NOP_INSTR;
                    valid_d = 1'b0;
                end
            end
            if (rsp_take && !rsp_to_out) begin
                buf_valid_d = 1'b1;
                buf_data_d  = bus.imem_rsp_data;
                buf_pc_d    = req_pc_q;
            end
        end
    end

    // Request sequencing and redirect handling.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        kill_d     = kill_q;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                if (req_fire) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = StWait;
                    if (jump) kill_d = 1'b1;
                end
            end
            StWait: begin
                if (bus.imem_rsp_valid) begin
                    if (kill_q || jump) begin
                        kill_d  = 1'b0;
                        state_d = StReq;
                    end else begin
                        fetch_pc_d = req_pc_q + 32'd4;
                        state_d    = buf_valid_d ? StHold : StReq;
                    end
                end else if (jump) begin
                    // The in-flight word belongs to the old path; drop it on arrival.
                    kill_d = 1'b1;
                end
            end
            StHold: begin
                if (jump || !buf_valid_d) state_d = StReq;
            end
        endcase

        if (jump) fetch_pc_d = target;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= 32'h0;
            kill_q      <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 32'h0;
            buf_pc_q    <= 32'h0;
            instr_q     <= NOP_INSTR;
            pc_q        <= 32'h0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            kill_q      <= kill_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.imem_req_valid = (state_q == StReq);
    assign bus.imem_addr      = fetch_pc_q;
    assign bus.instruction    = instr_q;
    assign bus.instr_pc       = pc_q;
    assign bus.instr_valid    = valid_q;

    // The buffer only ever holds a word while requests are paused.
    assert property (@(posedge clk) disable iff (reset) buf_valid_q |-> state_q == StHold);
    assert property (@(posedge clk) disable iff (reset) kill_q |-> state_q == StWait);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: random memory latency/readiness, stalls and
// redirects checked against an in-order PC-stream model; plus a wrap-around instance.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

    logic clk;
    logic reset;
    logic rst_w;

    instr_fetch_unit_if bus ();
    instr_fetch_unit_if bus_w ();

    instr_fetch_unit u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    instr_fetch_unit #(
        .RESET_PC(WRAP_PC)
    ) u_dut_wrap (
        .clk  (clk),
        .reset(rst_w),
        .bus  (bus_w.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    mem_req_t    mq[$];
    int          n_checks = 0;
    int          n_bad = 0;
    int          n_consumed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0F0F_00F0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic run_wrap_test();
        logic [31:0] got[4];
        logic [31:0] exp_a;
        logic [31:0] pend_addr;
        logic        pend;
        int          n;
        pend      = 1'b0;
        pend_addr = 32'h0;
        n         = 0;
        bus_w.imem_req_ready     = 1'b1;
        bus_w.imem_rsp_valid     = 1'b0;
        bus_w.imem_rsp_data      = 32'h0;
        bus_w.jump_branch_enable = 1'b0;
        bus_w.jump_target        = 32'h0;
        bus_w.stall              = 1'b0;
        @(negedge clk);
        check_eq("wrap_rst_addr", bus_w.imem_addr, WRAP_PC);
        rst_w = 1'b0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            bus_w.imem_rsp_valid = pend;
            bus_w.imem_rsp_data  = mem_word(pend_addr);
            pend = 1'b0;
            if (bus_w.imem_req_valid) begin
                got[n]    = bus_w.imem_addr;
                pend_addr = bus_w.imem_addr;
                pend      = 1'b1;
                n++;
            end
        end
        check_eq("wrap_count", 32'(n), 32'd4);
        exp_a = WRAP_PC;
        for (int k = 0; k < n; k++) begin
            check_eq($sformatf("wrap_addr%0d", k), got[k], exp_a);
            exp_a = exp_a + 32'd4;
        end
        bus_w.imem_rsp_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic [31:0] exp_req;
        logic [31:0] hold_instr;
        logic [31:0] hold_pc;
        logic        hold_prev;
        logic        jump_prev;
        logic        accept;
        int          cyc;

        reset = 1'b1;
        rst_w = 1'b1;
        bus.imem_req_ready     = 1'b0;
        bus.imem_rsp_valid     = 1'b0;
        bus.imem_rsp_data      = 32'h0;
        bus.jump_branch_enable = 1'b0;
        bus.jump_target        = 32'h0;
        bus.stall              = 1'b0;
        exp_pc    = 32'h0;
        exp_req   = 32'h0;
        hold_prev = 1'b0;
        jump_prev = 1'b0;
        hold_instr = 32'h0;
        hold_pc   = 32'h0;

        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_eq("rst_instr", bus.instruction, NOP);
        check_eq("rst_pc", bus.instr_pc, 32'h0);
        check_eq("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_eq("rst_addr", bus.imem_addr, 32'h0);

        run_wrap_test();

        @(negedge clk);
        reset = 1'b0;

        for (cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);

            if (cyc == 1500) begin
                // Asynchronous reset with decode stalled, then stale responses to ignore.
                bus.stall = 1'b1;
                #2 reset = 1'b1;
                #1;
                check_eq("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
                check_eq("mid_rst_instr", bus.instruction, NOP);
                check_eq("mid_rst_pc", bus.instr_pc, 32'h0);
                check_eq("mid_rst_req", 32'(bus.imem_req_valid), 32'd0);
                check_eq("mid_rst_addr", bus.imem_addr, 32'h0);
                repeat (2) @(negedge clk);
                reset = 1'b0;
                mq.delete();
                bus.imem_req_ready     = 1'b0;
                bus.jump_branch_enable = 1'b0;
                bus.stall              = 1'b0;
                bus.imem_rsp_valid     = 1'b1;
                bus.imem_rsp_data      = 32'hDEAD_BEEF;
                @(negedge clk);
                check_eq("post_rst_req", 32'(bus.imem_req_valid), 32'd1);
                check_eq("post_rst_addr", bus.imem_addr, 32'h0);
                @(negedge clk);
                check_eq("stale_ignored", 32'(bus.instr_valid), 32'd0);
                bus.imem_rsp_valid = 1'b0;
                exp_pc    = 32'h0;
                exp_req   = 32'h0;
                hold_prev = 1'b0;
                jump_prev = 1'b0;
                continue;
            end

            if (bus.imem_req_valid) check_eq("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            if (!bus.instr_valid) check_eq("nop_idle", bus.instruction, NOP);
            if (jump_prev) check_eq("redirect_kill", 32'(bus.instr_valid), 32'd0);
            if (hold_prev) begin
                check_eq("hold_valid", 32'(bus.instr_valid), 32'd1);
                check_eq("hold_instr", bus.instruction, hold_instr);
                check_eq("hold_pc", bus.instr_pc, hold_pc);
            end

            bus.stall = ($urandom_range(0, 3) == 0) || ((cyc % 200) >= 50 && (cyc % 200) < 56);
            bus.imem_req_ready     = ($urandom_range(0, 3) != 0);
            bus.jump_branch_enable = ($urandom_range(0, 39) == 0);
            bus.jump_target        = $urandom;
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom;
            end

            accept = bus.imem_req_valid && bus.imem_req_ready;
            if (accept) begin
                check_eq("one_outstanding", 32'(mq.size()), 32'd0);
                check_eq("req_addr", bus.imem_addr, exp_req);
                mq.push_back('{addr: bus.imem_addr, due: cyc + int'($urandom_range(1, 3))});
                exp_req = exp_req + 32'd4;
            end

            if (bus.instr_valid && !bus.stall && !bus.jump_branch_enable) begin
                check_eq("instr_pc", bus.instr_pc, exp_pc);
                check_eq("instr_data", bus.instruction, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                n_consumed++;
            end

            hold_prev  = bus.instr_valid && bus.stall && !bus.jump_branch_enable;
            hold_instr = bus.instruction;
            hold_pc    = bus.instr_pc;
            jump_prev  = bus.jump_branch_enable;
            if (bus.jump_branch_enable) begin
                exp_pc  = {bus.jump_target[31:2], 2'b00};
                exp_req = {bus.jump_target[31:2], 2'b00};
            end
        end

        check_eq("progress", 32'(n_consumed > 200), 32'd1);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage: the producer side of the instruction interface consumed by decode_logic.
- Generates sequential PCs and issues word reads to instruction memory over a valid/ready request and valid response interface.
- Presents each fetched word with its PC and a valid flag to decode, and redirects on jump/branch.
- Allows one outstanding memory request and has a one-entry holding buffer for decode stalls.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, value driven on instruction when not valid (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  fetch address, word aligned
- imem_rsp_valid  in  1  read data valid
- imem_rsp_data  in  32  read data
- jump_branch_enable  in  1  redirect strobe from execute
- jump_target  in  32  redirect address
- stall  in  1  decode cannot take a new instruction this cycle
- instruction  out  32  instruction to decode
- instr_pc  out  32  PC of instruction
- instr_valid  out  1  instruction/instr_pc valid

Behaviour:
- Reset values (asynchronous):
  - imem_req_valid=0, imem_addr=RESET_PC, instruction=NOP_INSTR, instr_pc=0, instr_valid=0.
  - Buffer empty, kill flag clear, state IDLE.
- States and transitions:
  - IDLE: one cycle after reset release, then REQ.
  - REQ: imem_req_valid=1 and imem_addr=fetch_pc. Request accepted when valid&&ready; record req_pc=fetch_pc and go to WAIT.
  - WAIT: wait for imem_rsp_valid. The response arrives at least 1 cycle after accept; memory is in-order.
    - Response with kill clear: word goes to the output register if free, else to the buffer. Set fetch_pc=req_pc+4.
    - Next state is REQ if the buffer is empty after this cycle, else HOLD.
  - HOLD: no request issued. When the buffer drains, go to REQ.
- Output register:
  - Loads when !instr_valid || !stall.
  - Source priority: buffer, then incoming response. If neither is present, instr_valid=0 and instruction=NOP_INSTR.
  - While instr_valid && stall, instruction, instr_pc and instr_valid hold.
- Latency: request accept to instr_valid with no stall is 1 cycle after imem_rsp_valid (registered output).
- Redirect (jump_branch_enable=1, any state, has precedence):
  - Next cycle: instr_valid=0, instruction=NOP_INSTR, buffer cleared, fetch_pc={jump_target[31:2],2'b00}.
  - In REQ: the unaccepted request is withdrawn; imem_addr shows the target next cycle.
  - In WAIT, or when the request is accepted in the same cycle: set kill. The next response is discarded and kill is cleared; then go to REQ.
  - A redirect coinciding with imem_rsp_valid discards that response.
  - A second redirect while kill is set only updates fetch_pc.
- Arithmetic: fetch_pc increment is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Stall does not block request issue while the buffer is empty.
- Reset mid-operation: all state returns to reset values immediately. Any response arriving after reset release and before the first new request is accepted is ignored.

Test Plan:
- Reset, imem always ready, 1-cycle response returning data=addr: instr_pc sequences 0,4,8,…; instruction=pc each valid cycle; imem_addr never misaligned.
- stall=1 for 5 cycles while valid at pc=8:
  - instruction and instr_pc hold at 8.
  - The pc=C word lands in the buffer and no further request is issued.
  - On release, pcs 8,C,10 appear in order with none lost or duplicated.
- Redirect to 32'h0000_0103 while in WAIT for pc=10:
  - instr_valid drops next cycle.
  - The pc=10 response is discarded.
  - The next request addr=32'h100, then instr_pc=100,104.
- Redirect in same cycle as imem_rsp_valid and with imem_req_ready=0 in REQ: the response is dropped, the pending request is withdrawn, and the next imem_addr equals the target.
- RESET_PC=32'hFFFF_FFF8: fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert reset mid-WAIT with stall=1: outputs return immediately to NOP_INSTR/0/0; after release, the first request is at RESET_PC.
